// File: rtl/game_pkg.sv
// Shared types and helpers for the round timer.
// Holds the timer state encoding, the BCD digit type, the reload
// conversion used for GAME_SECONDS and the divider width helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int DEFAULT_CLK_HZ  = 32'sd50000000;
    localparam int DEFAULT_TICK_HZ = 32'sd1;
    localparam int DEFAULT_DIV     = DEFAULT_CLK_HZ / DEFAULT_TICK_HZ;
    localparam int DEFAULT_DIV_W   = $clog2(DEFAULT_DIV);

    // Counter width able to hold 0..div-1; never narrower than one bit.
    function automatic int div_width(input int div);
        int w;
        if (div < 32'sd2) begin
            w = 32'sd1;
        end else begin
            w = $clog2(div);
        end
        return w;
    endfunction

    // Two-digit BCD image {tens, ones} of a value in 0..99.
    function automatic logic [7:0] to_bcd(input int value);
        logic [7:0] bcd;
        bcd[7:4] = 4'(value / 32'sd10);
        bcd[3:0] = 4'(value % 32'sd10);
        return bcd;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Free-running modulo-DIV cycle counter producing the countdown tick.
// Counts only while en is high; clr returns it to zero and masks the tick.
module rate_divider
    import game_pkg::*;
#(
    parameter int DIV   = 32'sd50000000,
    parameter int DIV_W = div_width(DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(32'd0);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 32'sd1);

    logic [DIV_W-1:0] count_r;
    logic             at_last_s;

    // Wrap detection: tick fires on the cycle the counter rolls over.
    always_comb begin
        at_last_s = (count_r == CNT_LAST);
        if (en && !clr) begin
            tick = at_last_s;
        end else begin
            tick = 1'b0;
        end
    end

    // Divider register: clear beats count, count wraps at DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (en) begin
            if (at_last_s) begin
                count_r <= CNT_ZERO;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Round countdown timer for the game FSM.
// Divides clk down to TICK_HZ, counts GAME_SECONDS down in two BCD digits
// and raises timer_signal once the round reaches 00.
// Optional build macro GAME_TIMER_WARN_EN: blinks warn at DIV/4 cycles per
// half-period while running or paused with 5 s or less remaining; without it
// warn is constant 0.
module game_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 32'sd50000000,
    parameter int TICK_HZ      = 32'sd1,
    parameter int GAME_SECONDS = 32'sd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic       timer_signal,
    output logic       expired_pulse,
    output logic       sec_tick,
    output logic       running,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       warn
);

    localparam int         DIV         = CLK_HZ / TICK_HZ;
    localparam int         DIV_W       = div_width(DIV);
    localparam logic [7:0] RELOAD_BCD  = to_bcd(GAME_SECONDS);
    localparam bcd_digit_t RELOAD_TENS = RELOAD_BCD[7:4];
    localparam bcd_digit_t RELOAD_ONES = RELOAD_BCD[3:0];
    localparam logic       RELOAD_ZERO = (GAME_SECONDS == 32'sd0);

    timer_state_e state_r;
    timer_state_e state_s;
    bcd_digit_t   tens_r;
    bcd_digit_t   ones_r;
    bcd_digit_t   tens_s;
    bcd_digit_t   ones_s;
    logic         div_en_s;
    logic         div_clr_s;
    logic         div_tick_s;
    logic         tick_s;
    logic         expire_s;
    logic         sec_tick_r;
    logic         expired_pulse_r;
    logic         running_r;
    logic         timer_signal_r;

    rate_divider #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_rate_divider (
        .clk   (clk),
        .reset (reset),
        .en    (div_en_s),
        .clr   (div_clr_s),
        .tick  (div_tick_s)
    );

    // Divider control: it counts only in RUN and restarts on any reload.
    always_comb begin
        div_en_s  = (state_r == ST_RUN);
        div_clr_s = clear | start;
    end

    // Next state, next digits and pulse events; clear > start > pause.
    always_comb begin
        state_s  = state_r;
        tens_s   = tens_r;
        ones_s   = ones_r;
        tick_s   = 1'b0;
        expire_s = 1'b0;
        if (clear) begin
            state_s = ST_IDLE;
            tens_s  = RELOAD_TENS;
            ones_s  = RELOAD_ONES;
        end else if (start) begin
            tens_s = RELOAD_TENS;
            ones_s = RELOAD_ONES;
            if (RELOAD_ZERO) begin
                state_s  = ST_EXPIRED;
                expire_s = 1'b1;
            end else begin
                state_s = ST_RUN;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (tens_r == 4'd0 && ones_r == 4'd0) begin
                        // Already at 00 without having expired: settle there.
                        state_s  = ST_EXPIRED;
                        expire_s = 1'b1;
                    end else if (div_tick_s) begin
                        tick_s = 1'b1;
                        if (ones_r == 4'd0) begin
                            ones_s = 4'd9;
                            tens_s = tens_r - 4'd1;
                        end else begin
                            ones_s = ones_r - 4'd1;
                        end
                        // Expiry outranks a pause arriving on the same tick.
                        if (tens_r == 4'd0 && ones_r == 4'd1) begin
                            state_s  = ST_EXPIRED;
                            expire_s = 1'b1;
                        end else if (pause) begin
                            state_s = ST_PAUSE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else if (pause) begin
                        state_s = ST_PAUSE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_s = ST_PAUSE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    state_s = ST_EXPIRED;
                    tens_s  = 4'd0;
                    ones_s  = 4'd0;
                end
                default: begin
                    state_s = ST_IDLE;
                    tens_s  = RELOAD_TENS;
                    ones_s  = RELOAD_ONES;
                end
            endcase
        end
    end

    // State, digits and all status outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            tens_r          <= RELOAD_TENS;
            ones_r          <= RELOAD_ONES;
            sec_tick_r      <= 1'b0;
            expired_pulse_r <= 1'b0;
            running_r       <= 1'b0;
            timer_signal_r  <= 1'b0;
        end else begin
            state_r         <= state_s;
            tens_r          <= tens_s;
            ones_r          <= ones_s;
            sec_tick_r      <= tick_s;
            expired_pulse_r <= expire_s;
            running_r       <= (state_s == ST_RUN);
            timer_signal_r  <= (state_s == ST_EXPIRED);
        end
    end

    assign timer_signal  = timer_signal_r;
    assign expired_pulse = expired_pulse_r;
    assign sec_tick      = sec_tick_r;
    assign running       = running_r;
    assign sec_tens      = tens_r;
    assign sec_ones      = ones_r;

`ifdef GAME_TIMER_WARN_EN
    localparam int               BLINK_Q    = DIV / 32'sd4;
    localparam int               BLINK_W    = div_width(BLINK_Q);
    localparam logic [BLINK_W-1:0] BLINK_ZERO = BLINK_W'(32'd0);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(32'd1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_Q - 32'sd1);

    logic [BLINK_W-1:0] blink_cnt_r;
    logic               warn_r;
    logic               warn_zone_s;

    // Low-time zone: live round (running or paused) with 5 s or less left.
    always_comb begin
        warn_zone_s = ((state_s == ST_RUN) || (state_s == ST_PAUSE)) &&
                      (tens_s == 4'd0) && (ones_s <= 4'd5);
    end

    // Blink generator: toggles warn every DIV/4 cycles inside the zone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_r <= BLINK_ZERO;
            warn_r      <= 1'b0;
        end else if (!warn_zone_s) begin
            blink_cnt_r <= BLINK_ZERO;
            warn_r      <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= BLINK_ZERO;
            warn_r      <= ~warn_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            warn_r      <= warn_r;
        end
    end

    assign warn = warn_r;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer.
// Two instances share stimulus: GAME_SECONDS=3 (main plan) and
// GAME_SECONDS=10 (BCD wrap 10 -> 09 -> 08). A second-count reference
// model predicts every output each cycle; directed checks pin the timing.
module tb_game_timer;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic pause;
    logic clear;

    logic       ts_o    [2];
    logic       exp_o   [2];
    logic       tick_o  [2];
    logic       run_o   [2];
    logic       warn_o  [2];
    logic [3:0] tens_o  [2];
    logic [3:0] ones_o  [2];

    int tests_run = 0;
    int fail_cnt  = 0;

    int gs [2] = '{3, 10};
    int m_mode  [2];
    int m_rem   [2];
    int m_phase [2];
    int m_wcnt  [2];
    bit m_tick  [2];
    bit m_exp   [2];

    game_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .GAME_SECONDS(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .timer_signal(ts_o[0]), .expired_pulse(exp_o[0]), .sec_tick(tick_o[0]),
        .running(run_o[0]), .sec_tens(tens_o[0]), .sec_ones(ones_o[0]), .warn(warn_o[0])
    );

    game_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .GAME_SECONDS(10)) u_dut10 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .timer_signal(ts_o[1]), .expired_pulse(exp_o[1]), .sec_tick(tick_o[1]),
        .running(run_o[1]), .sec_tens(tens_o[1]), .sec_ones(ones_o[1]), .warn(warn_o[1])
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Count a comparison and report it when observed differs from expected.
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]  = M_IDLE;
            m_rem[i]   = gs[i];
            m_phase[i] = 0;
            m_wcnt[i]  = 0;
            m_tick[i]  = 1'b0;
            m_exp[i]   = 1'b0;
        end
    endtask

    // One clock of the round rules, in remaining seconds and elapsed cycles.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 1'b0;
            m_exp[i]  = 1'b0;
            if (clear) begin
                m_mode[i]  = M_IDLE;
                m_rem[i]   = gs[i];
                m_phase[i] = 0;
            end else if (start) begin
                m_rem[i]   = gs[i];
                m_phase[i] = 0;
                if (gs[i] == 0) begin
                    m_mode[i] = M_EXP;
                    m_exp[i]  = 1'b1;
                end else begin
                    m_mode[i] = M_RUN;
                end
            end else if (m_mode[i] == M_RUN) begin
                m_phase[i]++;
                if (m_phase[i] == DIV) begin
                    m_phase[i] = 0;
                    m_rem[i]--;
                    m_tick[i] = 1'b1;
                end
                if (m_rem[i] == 0) begin
                    m_mode[i] = M_EXP;
                    m_exp[i]  = 1'b1;
                end else if (pause) begin
                    m_mode[i] = M_PAUSE;
                end
            end else if (m_mode[i] == M_PAUSE && !pause) begin
                m_mode[i] = M_RUN;
            end
            if ((m_mode[i] == M_RUN || m_mode[i] == M_PAUSE) && m_rem[i] <= 5) begin
                m_wcnt[i]++;
            end else begin
                m_wcnt[i] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec(input int i);
        logic w;
        logic [3:0] t;
        logic [3:0] o;
`ifdef GAME_TIMER_WARN_EN
        w = (((m_wcnt[i] / (DIV / 4)) % 2) == 1);
`else
        w = 1'b0;
`endif
        t = 4'(m_rem[i] / 10);
        o = 4'(m_rem[i] % 10);
        return 32'({m_mode[i] == M_EXP, m_exp[i], m_tick[i], m_mode[i] == M_RUN, w, t, o});
    endfunction

    function automatic logic [31:0] dut_vec(input int i);
        return 32'({ts_o[i], exp_o[i], tick_o[i], run_o[i], warn_o[i], tens_o[i], ones_o[i]});
    endfunction

    // Advance one clock, step the model, compare both instances on the falling edge.
    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_value("outs_gs3", dut_vec(0), exp_vec(0));
        check_value("outs_gs10", dut_vec(1), exp_vec(1));
    endtask

    // Assert reset between edges, check the asynchronous effect, release later.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_value("async_rst_gs3", dut_vec(0), exp_vec(0));
        check_value("async_rst_gs10", dut_vec(1), exp_vec(1));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int nt;
        int first;
        int tick_at [3];
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
        tick_at = '{0, 0, 0};

        // Reset state.
        do_reset();
        check_value("rst_digits", 32'({tens_o[0], ones_o[0]}), 32'h03);
        check_value("rst_running", 32'(run_o[0]), 32'd0);

        // Full round: ticks at 10, 20, 30; expiry with the third tick.
        start = 1'b1;
        tick_cycle();
        start = 1'b0;
        check_value("running_rise", 32'(run_o[0]), 32'd1);
        nt = 0;
        for (int k = 1; k <= 34; k++) begin
            tick_cycle();
            if (tick_o[0]) begin
                if (nt < 3) tick_at[nt] = k;
                nt++;
                if (nt == 3) check_value("exp_with_tick3", 32'(exp_o[0]), 32'd1);
            end
            if (k == 10) check_value("wrap_09", 32'({tens_o[1], ones_o[1]}), 32'h09);
            if (k == 20) check_value("wrap_08", 32'({tens_o[1], ones_o[1]}), 32'h08);
        end
        check_value("tick_count", 32'(nt), 32'd3);
        check_value("tick1_at", 32'(tick_at[0]), 32'd10);
        check_value("tick2_at", 32'(tick_at[1]), 32'd20);
        check_value("tick3_at", 32'(tick_at[2]), 32'd30);
        check_value("timer_hold", 32'(ts_o[0]), 32'd1);
        check_value("expired_digits", 32'({tens_o[0], ones_o[0]}), 32'h00);

        // Start while expired restarts the round.
        start = 1'b1;
        tick_cycle();
        start = 1'b0;
        check_value("restart_ts", 32'(ts_o[0]), 32'd0);
        check_value("restart_digits", 32'({tens_o[0], ones_o[0]}), 32'h03);
        check_value("restart_running", 32'(run_o[0]), 32'd1);

        // Pause 7 cycles after 4 counting cycles: first tick moves to 17.
        first = 0;
        for (int k = 1; k <= 25; k++) begin
            pause = (k >= 5 && k <= 11);
            tick_cycle();
            if (tick_o[0] && first == 0) first = k;
            if (k == 11) begin
                check_value("pause_digits", 32'({tens_o[0], ones_o[0]}), 32'h03);
                check_value("pause_running", 32'(run_o[0]), 32'd0);
            end
        end
        pause = 1'b0;
        check_value("paused_tick_at", 32'(first), 32'd17);

        // Clear back to idle.
        clear = 1'b1;
        tick_cycle();
        clear = 1'b0;
        check_value("clear_running", 32'(run_o[0]), 32'd0);

        // Start with pause held: one RUN cycle then PAUSE, divider at 1.
        start = 1'b1;
        pause = 1'b1;
        tick_cycle();
        start = 1'b0;
        check_value("sp_run", 32'(run_o[0]), 32'd1);
        tick_cycle();
        check_value("sp_paused", 32'(run_o[0]), 32'd0);
        tick_cycle();
        pause = 1'b0;
        first = 0;
        for (int j = 1; j <= 20; j++) begin
            tick_cycle();
            if (tick_o[0] && first == 0) first = j;
        end
        check_value("sp_tick_after", 32'(first), 32'd10);

        // Asynchronous reset mid-round once the digits read 02.
        start = 1'b1;
        tick_cycle();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if ({tens_o[0], ones_o[0]} != 8'h02) tick_cycle();
        end
        check_value("pre_rst_digits", 32'({tens_o[0], ones_o[0]}), 32'h02);
        #2;
        reset = 1'b1;
        #1;
        check_value("mid_rst_digits", 32'({tens_o[0], ones_o[0]}), 32'h03);
        check_value("mid_rst_running", 32'(run_o[0]), 32'd0);
        do_reset();

        // Randomized requests, pause bursts and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 249) == 0);
            clear = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 799) == 0) begin
                #2;
                do_reset();
            end
            tick_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
